// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the instruction memory from the fetch PC and queues {pc, instr} pairs for decode.
// One-cycle fetch-to-decode latency; fetch stalls when the buffer is full and decode is not popping.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_BYTES = 28
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        end_o
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);
  localparam logic [32:0] LIMIT   = 33'(IMEM_BYTES);

  logic [31:0]   fpc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic          pop;
  logic          push;

  // 33-bit compare so a fetch PC near 2^32 cannot wrap back into range.
  assign end_o       = ({1'b0, fpc} + 33'd4) > LIMIT;
  assign imem_addr_o = fpc;
  assign valid_o     = (count != '0);
  assign pc_o        = pc_q[rd_ptr];
  assign instr_o     = instr_q[rd_ptr];

  assign pop  = valid_o & ready_i;
  assign push = !redirect_i & !end_o & ((count < DEPTH_C) | pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fpc    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (redirect_i) begin
      // Any same-cycle pop has already been taken by decode; the rest is dropped.
      fpc    <= redirect_pc_i & ~32'd3;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]    <= fpc;
        instr_q[wr_ptr] <= imem_instr_i;
        wr_ptr          <= wr_ptr + PW'(1);
        fpc             <= fpc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + (PW + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (PW + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a 7-word behavioural instruction memory.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        end_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (2),
    .IMEM_BYTES(28)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem_addr_o  (imem_addr),
    .imem_instr_i (imem_instr),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .valid_o      (valid),
    .ready_i      (ready),
    .instr_o      (instr),
    .pc_o         (pc),
    .end_o        (end_flag)
  );

  function automatic logic [31:0] word(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  // Combinational memory: W0..W6 at bytes 0..27, a marker word elsewhere.
  always_comb begin
    imem_instr = 32'hDEAD_BEEF;
    if (imem_addr[31:2] < 30'd7) imem_instr = word(int'(imem_addr[31:2]));
  end

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] redir_pc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
    logic        exp_end;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic [31:0] rpc,
                     input logic v, input logic [31:0] p, input logic [31:0] ins,
                     input logic [31:0] a, input logic e);
    vec_t t;
    t.rdy = r; t.redir = rd; t.redir_pc = rpc;
    t.exp_valid = v; t.exp_pc = p; t.exp_instr = ins; t.exp_addr = a; t.exp_end = e;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Streaming run from reset with ready high: one instruction per edge.
    add(1, 0, 0, 1, 32'h00, word(0), 32'h04, 0);
    add(1, 0, 0, 1, 32'h04, word(1), 32'h08, 0);
    add(1, 0, 0, 1, 32'h08, word(2), 32'h0C, 0);
    add(1, 0, 0, 1, 32'h0C, word(3), 32'h10, 0);
    add(1, 0, 0, 1, 32'h10, word(4), 32'h14, 0);
    add(1, 0, 0, 1, 32'h14, word(5), 32'h18, 0);
    add(1, 0, 0, 1, 32'h18, word(6), 32'h1C, 1);
    add(1, 0, 0, 0, 32'h00, 32'h0,   32'h1C, 1);
    add(1, 0, 0, 0, 32'h00, 32'h0,   32'h1C, 1);
    // Redirect out of the end state, then resume at 8.
    add(1, 1, 32'h08, 0, 32'h00, 32'h0,   32'h08, 0);
    add(1, 0, 0,      1, 32'h08, word(2), 32'h0C, 0);
    add(1, 0, 0,      1, 32'h0C, word(3), 32'h10, 0);
    // Unaligned target, then out-of-range target.
    add(1, 1, 32'h13, 0, 32'h00, 32'h0,   32'h10, 0);
    add(1, 0, 0,      1, 32'h10, word(4), 32'h14, 0);
    add(1, 1, 32'h40, 0, 32'h00, 32'h0,   32'h40, 1);
    add(1, 0, 0,      0, 32'h00, 32'h0,   32'h40, 1);
    add(1, 0, 0,      0, 32'h00, 32'h0,   32'h40, 1);
    // Restart at 0, then redirect to 0x10 while pc 4 is at the head.
    add(1, 1, 32'h00, 0, 32'h00, 32'h0,   32'h00, 0);
    add(1, 0, 0,      1, 32'h00, word(0), 32'h04, 0);
    add(1, 0, 0,      1, 32'h04, word(1), 32'h08, 0);
    add(1, 1, 32'h10, 0, 32'h00, 32'h0,   32'h10, 0);
    add(1, 0, 0,      1, 32'h10, word(4), 32'h14, 0);

    rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_end", 32'(end_flag), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      ready = vecs[i].rdy;
      redirect = vecs[i].redir;
      redirect_pc = vecs[i].redir_pc;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_end", i), 32'(end_flag), 32'(vecs[i].exp_end));
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
        chk($sformatf("v%0d_instr", i), instr, vecs[i].exp_instr);
      end
    end
    redirect = 1'b0;

    // Stall: ready low after reset fills the buffer and freezes the fetch PC.
    rst_n = 1'b0; ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall%0d_valid", k), 32'(valid), 32'd1);
      chk($sformatf("stall%0d_pc", k), pc, 32'h0);
      chk($sformatf("stall%0d_instr", k), instr, word(0));
      chk($sformatf("stall%0d_addr", k), imem_addr, (k == 0) ? 32'h4 : 32'h8);
    end
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      chk($sformatf("drain%0d_valid", k), 32'(valid), 32'd1);
      chk($sformatf("drain%0d_pc", k), pc, 32'(4 * k));
      chk($sformatf("drain%0d_instr", k), instr, word(k));
    end

    // Hold two entries, then assert reset between clock edges.
    ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rerun0_valid", 32'(valid), 32'd1);
    chk("rerun0_pc", pc, 32'h0);
    chk("rerun0_instr", instr, word(0));
    @(posedge clk);
    @(negedge clk);
    chk("rerun1_pc", pc, 32'h4);
    chk("rerun1_instr", instr, word(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage between the PC logic and the combinational byte-addressed little-endian `instruction_memory`. Holds the fetch PC and drives the memory address. Captures the returned 32-bit word into a small prefetch buffer. Presents {pc, instruction} pairs to decode over a valid/ready handshake, and supports redirects (branch/jump) that flush the buffer.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch PC after reset; must be a multiple of 4.
- `DEPTH`, 2: prefetch buffer entries; power of 2, at least 2.
- `IMEM_BYTES`, 28: instruction memory size in bytes; must be a multiple of 4.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `imem_addr_o`  out  32  byte address to `instruction_memory.address_i`; equals the fetch PC register.
- `imem_instr_i`  in  32  word from `instruction_memory.instruction_o`; combinational, valid in the same cycle.
- `redirect_i`  in  1  flush and restart fetch at `redirect_pc_i`.
- `redirect_pc_i`  in  32  redirect target; bits [1:0] are ignored.
- `valid_o`  out  1  buffer head holds an instruction.
- `ready_i`  in  1  decode accepts the head this cycle.
- `instr_o`  out  32  instruction at the buffer head.
- `pc_o`  out  32  PC of the instruction at the buffer head.
- `end_o`  out  1  fetch PC is past the end of memory; no further fetches.

## Operation
- State:
  - fetch PC register `fpc`.
  - Circular buffer of `DEPTH` entries {pc, instr}, with read/write pointers and `count` (0..DEPTH).
- Reset (asynchronous, on `rst_ni` low): `fpc`=`RESET_PC`, pointers and count=0, all buffer storage=0.
  - Outputs in reset: `valid_o`=0, `instr_o`=0, `pc_o`=0, `imem_addr_o`=`RESET_PC`.
  - `end_o` = (`RESET_PC` + 4 > `IMEM_BYTES`).
- `end_o` = (`fpc` + 4 > `IMEM_BYTES`), combinational from `fpc`, compared in 33 bits so wrap cannot alias.
- `pop` = `valid_o` & `ready_i`.
- `push` = !`redirect_i` & !`end_o` & (`count` < `DEPTH` | `pop`).
  - On push: write {`fpc`, `imem_instr_i`} at the write pointer, and set `fpc` ← `fpc` + 4 (mod 2^32).
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointers wrap modulo `DEPTH`.
- Redirect (highest priority):
  - At the edge with `redirect_i`=1: `count`←0, pointers←0, `fpc`←{`redirect_pc_i`[31:2], 2'b00}; no push.
  - A pop in the same cycle is still a completed transfer for decode; the remaining entries are discarded.
- `valid_o` = (`count` != 0). `instr_o` and `pc_o` come from buffer storage at the read pointer; no combinational path from `imem_instr_i`.
- While `valid_o`=1 and `ready_i`=0, `instr_o` and `pc_o` are held stable until popped or a redirect occurs.
- A redirect to an in-range target clears `end_o` and fetching resumes.
- A redirect to an out-of-range target sets `end_o` and leaves the buffer empty.

## Timing
- Memory path: `imem_addr_o` is registered; `imem_instr_i` is sampled in the same cycle (single-cycle combinational memory).
- Fetch-to-decode latency:
  - First instruction is valid one cycle after reset release, i.e. after the first rising edge with `rst_ni` high.
  - After a redirect edge, the target instruction is valid one cycle later.
  - `valid_o`=0 during the intervening cycle.
- Throughput: one instruction per cycle with `ready_i` held high, including while the buffer is full (simultaneous push and pop).
- Boundary conditions:
  - Buffer full with no pop: `fpc` holds and `imem_addr_o` is stable.
  - Buffer empty with `end_o`=1: `valid_o` stays 0 indefinitely.
  - `redirect_i` and `ready_i` together: redirect wins for buffer state.
  - `rst_ni` asserted mid-cycle: outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
- Memory holds W0..W6 at bytes 0..27; release reset with `ready_i`=1:
  - `pc_o`/`instr_o` = 0/W0, 4/W1, … 24/W6 on consecutive cycles.
  - Then `valid_o`=0, `end_o`=1, `imem_addr_o`=28.
- Same memory, `ready_i`=0 after reset:
  - Buffer fills with pc 0 and 4; `imem_addr_o` stalls at 8; `pc_o`=0 held stable.
  - Raise `ready_i` → pcs 0, 4, 8, 12 on four consecutive cycles.
- Pc 4 at head, `ready_i`=1; pulse `redirect_i` with `redirect_pc_i`=0x10:
  - Next cycle `valid_o`=0.
  - Following cycle `pc_o`=0x10, `instr_o`=W4.
- Redirect to 0x13 → `imem_addr_o`=0x10 and `pc_o`=0x10. Redirect to 0x40 → `end_o`=1 and `valid_o` stays 0.
- With `end_o`=1, redirect to 0x8 → `end_o`=0, then pcs 8, 12, … resume.
- Drop `rst_ni` between clock edges while the buffer holds 2 entries:
  - `valid_o`=0, `pc_o`=0, `instr_o`=0, `imem_addr_o`=`RESET_PC` immediately.
  - After release, restart from pc 0.
